nibble_serial_adder_ctrl: RTL and testbench

- Multi-cycle wide adder/subtractor that computes one 4-bit nibble per clock, keeping the inter-nibble carry in a register.
- Lets WIDTH-bit additions share one 4-bit ripple-carry slice instead of instantiating WIDTH/4 slices.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/add_ctrl_pkg.sv | 12 +
 rtl/nibble_adder_slice.sv | 24 ++
 rtl/nibble_serial_adder_ctrl.sv | 137 +++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_adder_slice.sv
// 4-bit ripple-carry adder assembled from 1-bit full-adder cells.
module nibble_adder_slice
  import add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] sum,
  output logic                co
);

  logic [NIBBLE_W:0] w_carry;

  assign w_carry[0] = ci;

  for (genvar g = 0; g < NIBBLE_W; g++) begin : g_fa
    // One full-adder cell; carry ripples to the next bit.
    assign sum[g]       = a[g] ^ b[g] ^ w_carry[g];
    assign w_carry[g+1] = (a[g] & b[g]) | (w_carry[g] & (a[g] ^ b[g]));
  end

  assign co = w_carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single
// shared 4-bit slice, with valid/ready handshakes on both sides.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready=1, waiting for operands; last result still on sum
// RUN   | one nibble per edge, idx walks 0..NIBBLES-1
// DONE  | out_valid=1, result held until out_ready
module nibble_serial_adder_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [NIBBLE_W-1:0] w_nib_a;
  logic [NIBBLE_W-1:0] w_nib_b;
  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_co;
  logic [WIDTH-1:0]    w_sum_next;
  logic                w_last;
  logic                w_accept;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == IDX_LAST);
  assign w_nib_a  = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
  assign w_nib_b  = r_b[NIBBLE_W*r_idx +: NIBBLE_W];

  nibble_adder_slice u_slice (
    .a   (w_nib_a),
    .b   (w_nib_b),
    .ci  (r_carry),
    .sum (w_nib_sum),
    .co  (w_nib_co)
  );

  // Working sum with the current nibble merged in.
  always_comb begin
    w_sum_next = r_work;
    w_sum_next[NIBBLE_W*r_idx +: NIBBLE_W] = w_nib_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, nibble sequencing and result registers. The visible
  // result only changes on the RUN->DONE edge so it stays stable in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub ? 1'b1 : cin;
            r_work  <= '0;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_work  <= w_sum_next;
          r_carry <= w_nib_co;
          if (w_last) begin
            r_idx  <= '0;
            r_sum  <= w_sum_next;
            r_cout <= w_nib_co;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_nib_sum[NIBBLE_W-1] != r_a[WIDTH-1]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder controller (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[10];

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid after an accepting edge; returns edges taken.
  task automatic wait_done(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, 4);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    a = v.a; b = v.b; cin = v.cin; op_sub = v.op_sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin; op_sub = ~v.op_sub;
    check({v.name, " busy"}, {31'b0, busy}, 1);
    wait_done(v.name, lat);
    check({v.name, " sum"},  {16'b0, sum}, {16'b0, v.exp_sum});
    check({v.name, " cout"}, {31'b0, cout}, {31'b0, v.exp_cout});
    check({v.name, " ovf"},  {31'b0, ovf},  {31'b0, v.exp_ovf});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({v.name, " release"}, {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int lat;
    int spurious;

    vecs[0] = '{"add_nocarry", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"ripple_b1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"ripple_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{"sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{"sub_noborrow",16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{"add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{"add_alt_cin", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{"add_negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[9] = '{"sub_equal",   16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    tick();
    tick();
    check("reset in_ready",  {31'b0, in_ready}, 1);
    check("reset out_valid", {31'b0, out_valid}, 0);
    check("reset busy",      {31'b0, busy}, 0);
    check("reset result",    {14'b0, sum, cout, ovf}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure with operand churn and a request held the whole time.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
      check("bp run in_ready", {31'b0, in_ready}, 0);
      tick();
    end
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; op_sub = 1'b0;
    tick();
    check("bp first valid", {31'b0, out_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp hold sum", {16'b0, sum}, 32'h3333);
      check("bp hold flags", {29'b0, out_valid, in_ready, cout}, 32'b100);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp idle cycle", {30'b0, in_ready, out_valid}, 32'b10);
    check("bp idle sum kept", {16'b0, sum}, 32'h3333);
    tick();
    check("bp second accepted", {30'b0, busy, in_ready}, 32'b10);
    in_valid = 1'b0;
    wait_done("bp second", lat);
    check("bp second sum", {16'b0, sum}, 32'h1010);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset pulse while idx=2 in RUN.
    a = 16'h1234; b = 16'h1111; op_sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst mid out_valid", {31'b0, out_valid}, 0);
    check("rst mid sum", {16'b0, sum}, 0);
    check("rst mid in_ready", {31'b0, in_ready}, 1);
    check("rst mid busy", {31'b0, busy}, 0);
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) spurious++;
      tick();
    end
    check("rst mid no completion", spurious, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
